// File: rtl/core_mem_lsu.sv
// MEM stage: passes non-memory ops through a valid/ready slice and runs loads/stores
// on a req/gnt/rvalid data bus, with lane steering, load extension and fault reporting.
//
// state | meaning
// IDLE  | empty, ready to accept
// REQ   | bus request raised, waiting for grant
// RESP  | granted, waiting for rvalid (read data or write acknowledge)
// OUT   | result presented to WB, waiting for out_ready_i
module core_mem_lsu #(
   parameter int XLEN        = 32,
   parameter int RFIDX_WIDTH = 5,
   parameter int PC_SIZE     = 32,
   parameter int INSTR_SIZE  = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [PC_SIZE-1:0]     pc_i,
   input  logic [INSTR_SIZE-1:0]  instr_i,
   input  logic [RFIDX_WIDTH-1:0] rsd_idx_i,
   input  logic                   rsd_we_i,
   input  logic [XLEN-1:0]        rsd_data_i,
   input  logic [XLEN-1:0]        rs2_data_i,
   input  logic                   is_load_i,
   input  logic                   is_store_i,
   input  logic [2:0]             funct3_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [PC_SIZE-1:0]     pc_o,
   output logic [INSTR_SIZE-1:0]  instr_o,
   output logic [RFIDX_WIDTH-1:0] rsd_idx_o,
   output logic                   rsd_we_o,
   output logic [XLEN-1:0]        rsd_data_o,
   output logic [1:0]             exc_o,
   output logic                   dbus_req_o,
   input  logic                   dbus_gnt_i,
   output logic                   dbus_we_o,
   output logic [XLEN-1:0]        dbus_addr_o,
   output logic [XLEN/8-1:0]      dbus_be_o,
   output logic [XLEN-1:0]        dbus_wdata_o,
   input  logic                   dbus_rvalid_i,
   input  logic [XLEN-1:0]        dbus_rdata_i,
   input  logic                   dbus_err_i
);
   localparam int NB   = XLEN / 8;
   localparam int OFFW = $clog2(NB);

   typedef enum logic [1:0] {IDLE, REQ, RESP, OUT} state_t;

   state_t                 r_state;
   logic [PC_SIZE-1:0]     r_pc;
   logic [INSTR_SIZE-1:0]  r_instr;
   logic [RFIDX_WIDTH-1:0] r_idx;
   logic                   r_we;
   logic [XLEN-1:0]        r_addr;
   logic [XLEN-1:0]        r_rs2;
   logic [XLEN-1:0]        r_result;
   logic                   r_is_load;
   logic                   r_is_store;
   logic [2:0]             r_funct3;
   logic [1:0]             r_exc;

   logic            w_accept;
   logic            w_in_mem;
   logic [2:0]      w_amask;
   logic            w_misaligned;
   logic [OFFW-1:0] w_off;
   logic [7:0]      w_be8;
   logic [XLEN-1:0] w_sh;
   logic [XLEN-1:0] w_ld;
   logic            w_in_req;

   assign in_ready_o = (r_state == IDLE) || ((r_state == OUT) && out_ready_i);
   assign w_accept   = in_valid_i && in_ready_o;
   assign w_in_mem   = is_load_i || is_store_i;
   assign w_off      = r_addr[OFFW-1:0];
   assign w_in_req   = (r_state == REQ);

   always_comb begin
      w_amask = 3'b000;
      case (funct3_i[1:0])
         2'd0:    w_amask = 3'b000;
         2'd1:    w_amask = 3'b001;
         2'd2:    w_amask = 3'b011;
         default: w_amask = 3'b111;
      endcase
   end
   assign w_misaligned = |(rsd_data_i[2:0] & w_amask);

   always_comb begin
      w_be8 = 8'h00;
      case (r_funct3[1:0])
         2'd0:    w_be8 = 8'h01;
         2'd1:    w_be8 = 8'h03;
         2'd2:    w_be8 = 8'h0F;
         default: w_be8 = 8'hFF;
      endcase
   end

   // Bus outputs are only driven while requesting so they read 0 out of reset.
   assign dbus_req_o   = w_in_req;
   assign dbus_we_o    = w_in_req && r_is_store;
   assign dbus_addr_o  = w_in_req ? {r_addr[XLEN-1:OFFW], {OFFW{1'b0}}} : '0;
   assign dbus_be_o    = w_in_req ? (w_be8[NB-1:0] << w_off) : '0;
   assign dbus_wdata_o = w_in_req ? (r_rs2 << {w_off, 3'b000}) : '0;

   always_comb begin
      w_sh = dbus_rdata_i >> {w_off, 3'b000};
      w_ld = w_sh;
      case (r_funct3[1:0])
         2'd0: w_ld = r_funct3[2] ? XLEN'(w_sh[7:0])  : XLEN'($signed(w_sh[7:0]));
         2'd1: w_ld = r_funct3[2] ? XLEN'(w_sh[15:0]) : XLEN'($signed(w_sh[15:0]));
         2'd2: w_ld = r_funct3[2] ? XLEN'(w_sh[31:0]) : XLEN'($signed(w_sh[31:0]));
         default: w_ld = w_sh;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_pc       <= '0;
         r_instr    <= '0;
         r_idx      <= '0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_rs2      <= '0;
         r_result   <= '0;
         r_is_load  <= 1'b0;
         r_is_store <= 1'b0;
         r_funct3   <= 3'b000;
         r_exc      <= 2'd0;
      end else if (w_accept) begin
         r_pc       <= pc_i;
         r_instr    <= instr_i;
         r_idx      <= rsd_idx_i;
         r_we       <= rsd_we_i;
         r_addr     <= rsd_data_i;
         r_rs2      <= rs2_data_i;
         r_result   <= rsd_data_i;
         r_is_load  <= is_load_i;
         r_is_store <= is_store_i;
         r_funct3   <= funct3_i;
         if (!w_in_mem) begin
            r_state <= OUT;
            r_exc   <= 2'd0;
         end else if ((XLEN == 32) && (funct3_i[1:0] == 2'd3)) begin
            r_state <= OUT;
            r_exc   <= 2'd3;
         end else if (w_misaligned) begin
            r_state <= OUT;
            r_exc   <= 2'd1;
         end else begin
            r_state <= REQ;
            r_exc   <= 2'd0;
         end
      end else begin
         case (r_state)
            REQ:  if (dbus_gnt_i) r_state <= RESP;
            RESP: if (dbus_rvalid_i) begin
               if (r_is_load) r_result <= w_ld;
               if (dbus_err_i) r_exc <= 2'd2;
               r_state <= OUT;
            end
            OUT:  if (out_ready_i) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign out_valid_o = (r_state == OUT);
   assign pc_o        = r_pc;
   assign instr_o     = r_instr;
   assign rsd_idx_o   = r_idx;
   assign rsd_data_o  = r_result;
   assign exc_o       = r_exc;
   assign rsd_we_o    = r_we && (r_exc == 2'd0) && !r_is_store;
endmodule

// File: tb/tb_core_mem_lsu.sv
// Directed bench for core_mem_lsu (XLEN=32): vector table plus hand-written
// sequences for back-to-back flow, stalls and reset during a transaction.
module tb_core_mem_lsu;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid_i, in_ready_o;
   logic [31:0] pc_i, instr_i;
   logic [4:0]  rsd_idx_i;
   logic        rsd_we_i;
   logic [31:0] rsd_data_i, rs2_data_i;
   logic        is_load_i, is_store_i;
   logic [2:0]  funct3_i;
   logic        out_valid_o, out_ready_i;
   logic [31:0] pc_o, instr_o;
   logic [4:0]  rsd_idx_o;
   logic        rsd_we_o;
   logic [31:0] rsd_data_o;
   logic [1:0]  exc_o;
   logic        dbus_req_o, dbus_gnt_i, dbus_we_o;
   logic [31:0] dbus_addr_o;
   logic [3:0]  dbus_be_o;
   logic [31:0] dbus_wdata_o;
   logic        dbus_rvalid_i;
   logic [31:0] dbus_rdata_i;
   logic        dbus_err_i;

   int checks = 0;
   int failures = 0;

   core_mem_lsu dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .pc_i(pc_i), .instr_i(instr_i), .rsd_idx_i(rsd_idx_i), .rsd_we_i(rsd_we_i),
      .rsd_data_i(rsd_data_i), .rs2_data_i(rs2_data_i),
      .is_load_i(is_load_i), .is_store_i(is_store_i), .funct3_i(funct3_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .pc_o(pc_o), .instr_o(instr_o), .rsd_idx_o(rsd_idx_o), .rsd_we_o(rsd_we_o),
      .rsd_data_o(rsd_data_o), .exc_o(exc_o),
      .dbus_req_o(dbus_req_o), .dbus_gnt_i(dbus_gnt_i), .dbus_we_o(dbus_we_o),
      .dbus_addr_o(dbus_addr_o), .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
      .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i), .dbus_err_i(dbus_err_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        ld, st;
      logic [2:0]  f3;
      logic [31:0] addr, rs2, rdata;
      logic        err;
      logic        exp_req;
      logic [31:0] exp_daddr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_data;
      logic        exp_we;
      logic [1:0]  exp_exc;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input string nm, input logic ld, input logic st, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdata,
                               input logic err, input logic ereq, input logic [31:0] edaddr,
                               input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] edata,
                               input logic ewe, input logic [1:0] eexc);
      vec_t v;
      v.name = nm; v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.rs2 = rs2;
      v.rdata = rdata; v.err = err; v.exp_req = ereq; v.exp_daddr = edaddr; v.exp_be = ebe;
      v.exp_wdata = ewd; v.exp_data = edata; v.exp_we = ewe; v.exp_exc = eexc;
      return v;
   endfunction

   function automatic logic [31:0] lane_mask(input logic [3:0] be);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
      return m;
   endfunction

   task automatic drive_op(input logic [31:0] pc, input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rs2);
      in_valid_i = 1'b1; pc_i = pc; instr_i = ~pc; rsd_idx_i = pc[4:0]; rsd_we_i = 1'b1;
      is_load_i = ld; is_store_i = st; funct3_i = f3; rsd_data_i = addr; rs2_data_i = rs2;
   endtask

   task automatic run_vec(input vec_t v, input int k);
      logic saw_req;
      saw_req = 1'b0;
      @(negedge clk);
      drive_op(32'h100 + 32'(k * 4), v.ld, v.st, v.f3, v.addr, v.rs2);
      out_ready_i = 1'b0;
      @(negedge clk);
      in_valid_i = 1'b0;
      if (dbus_req_o) begin
         saw_req = 1'b1;
         chk({v.name, " addr"}, 64'(dbus_addr_o), 64'(v.exp_daddr));
         chk({v.name, " be"}, 64'(dbus_be_o), 64'(v.exp_be));
         chk({v.name, " we"}, 64'(dbus_we_o), 64'(v.st));
         if (v.st) chk({v.name, " wdata"}, 64'(dbus_wdata_o & lane_mask(v.exp_be)), 64'(v.exp_wdata));
         dbus_gnt_i = 1'b1;
         @(negedge clk);
         dbus_gnt_i = 1'b0;
         dbus_rvalid_i = 1'b1; dbus_rdata_i = v.rdata; dbus_err_i = v.err;
         @(negedge clk);
         dbus_rvalid_i = 1'b0; dbus_err_i = 1'b0;
      end
      chk({v.name, " req"}, 64'(saw_req), 64'(v.exp_req));
      chk({v.name, " out_valid"}, 64'(out_valid_o), 64'd1);
      chk({v.name, " data"}, 64'(rsd_data_o), 64'(v.exp_data));
      chk({v.name, " rd_we"}, 64'(rsd_we_o), 64'(v.exp_we));
      chk({v.name, " exc"}, 64'(exc_o), 64'(v.exp_exc));
      chk({v.name, " pc"}, 64'(pc_o), 64'(32'h100 + 32'(k * 4)));
      out_ready_i = 1'b1;
      @(negedge clk);
      out_ready_i = 1'b0;
      chk({v.name, " drained"}, 64'(out_valid_o), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
      pc_i = '0; instr_i = '0; rsd_idx_i = '0; rsd_we_i = 1'b0; rsd_data_i = '0; rs2_data_i = '0;
      is_load_i = 1'b0; is_store_i = 1'b0; funct3_i = '0;
      dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = '0; dbus_err_i = 1'b0;

      //          name     ld st f3    addr          rs2           rdata         err req daddr       be       wdata         data          we exc
      vecs.push_back(mk("LB",    1, 0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_FF7F, 0, 1, 32'h1000, 4'b1000, 32'h0,        32'hFFFF_FF80, 1, 0));
      vecs.push_back(mk("LBU",   1, 0, 3'b100, 32'h0000_1003, 32'h0,        32'h80FF_FF7F, 0, 1, 32'h1000, 4'b1000, 32'h0,        32'h0000_0080, 1, 0));
      vecs.push_back(mk("SH",    0, 1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0,        0, 1, 32'h2000, 4'b1100, 32'hABCD_0000, 32'h0000_2002, 0, 0));
      vecs.push_back(mk("LWmis", 1, 0, 3'b010, 32'h0000_3002, 32'h0,        32'h0,        0, 0, 32'h0,    4'b0000, 32'h0,        32'h0000_3002, 0, 1));
      vecs.push_back(mk("LH",    1, 0, 3'b001, 32'h0000_4002, 32'h0,        32'h8001_1234, 0, 1, 32'h4000, 4'b1100, 32'h0,        32'hFFFF_8001, 1, 0));
      vecs.push_back(mk("LHU",   1, 0, 3'b101, 32'h0000_4002, 32'h0,        32'h8001_1234, 0, 1, 32'h4000, 4'b1100, 32'h0,        32'h0000_8001, 1, 0));
      vecs.push_back(mk("LH0",   1, 0, 3'b001, 32'h0000_4000, 32'h0,        32'h8001_7234, 0, 1, 32'h4000, 4'b0011, 32'h0,        32'h0000_7234, 1, 0));
      vecs.push_back(mk("LW",    1, 0, 3'b010, 32'h0000_5004, 32'h0,        32'hDEAD_BEEF, 0, 1, 32'h5004, 4'b1111, 32'h0,        32'hDEAD_BEEF, 1, 0));
      vecs.push_back(mk("SB",    0, 1, 3'b000, 32'h0000_6001, 32'h0000_00A5, 32'h0,        0, 1, 32'h6000, 4'b0010, 32'h0000_A500, 32'h0000_6001, 0, 0));
      vecs.push_back(mk("LD32",  1, 0, 3'b011, 32'h0000_6008, 32'h0,        32'h0,        0, 0, 32'h0,    4'b0000, 32'h0,        32'h0000_6008, 0, 3));
      vecs.push_back(mk("LWerr", 1, 0, 3'b010, 32'h0000_7000, 32'h0,        32'h1111_2222, 1, 1, 32'h7000, 4'b1111, 32'h0,        32'h1111_2222, 0, 2));
      vecs.push_back(mk("SW",    0, 1, 3'b010, 32'h0000_8000, 32'hCAFE_F00D, 32'h0,        0, 1, 32'h8000, 4'b1111, 32'hCAFE_F00D, 32'h0000_8000, 0, 0));
      vecs.push_back(mk("LHmis", 1, 0, 3'b001, 32'h0000_9001, 32'h0,        32'h0,        0, 0, 32'h0,    4'b0000, 32'h0,        32'h0000_9001, 0, 1));
      vecs.push_back(mk("ALU",   0, 0, 3'b010, 32'h1111_2223, 32'h0,        32'h0,        0, 0, 32'h0,    4'b0000, 32'h0,        32'h1111_2223, 1, 0));

      #12;
      chk("rst in_ready", 64'(in_ready_o), 64'd1);
      chk("rst out_valid", 64'(out_valid_o), 64'd0);
      chk("rst req", 64'(dbus_req_o), 64'd0);
      chk("rst rd_we", 64'(rsd_we_o), 64'd0);
      chk("rst be", 64'(dbus_be_o), 64'd0);
      @(negedge clk); rst_n = 1'b1;

      foreach (vecs[k]) run_vec(vecs[k], k);

      // three back-to-back ALU ops at full throughput
      @(negedge clk);
      out_ready_i = 1'b1;
      drive_op(32'hA00, 0, 0, 3'b000, 32'h0000_00A0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("b2b valid", 64'(out_valid_o), 64'd1);
         chk("b2b pc", 64'(pc_o), 64'(32'hA00 + 32'(i)));
         chk("b2b data", 64'(rsd_data_o), 64'(32'hA0 + 32'(i)));
         chk("b2b in_ready", 64'(in_ready_o), 64'd1);
         if (i < 2) drive_op(32'hA01 + 32'(i), 0, 0, 3'b000, 32'h0000_00A1 + 32'(i), 32'h0);
         else in_valid_i = 1'b0;
      end
      @(negedge clk);
      chk("b2b drained", 64'(out_valid_o), 64'd0);
      out_ready_i = 1'b0;

      // stalls: grant late, response late, WB back-pressure
      drive_op(32'hB00, 1, 0, 3'b010, 32'h0000_5008, 32'h0);
      @(negedge clk);
      drive_op(32'hBFF, 0, 0, 3'b000, 32'hFFFF_FFFF, 32'h0);
      for (int i = 0; i < 3; i++) begin
         chk("stall req", 64'(dbus_req_o), 64'd1);
         chk("stall addr", 64'(dbus_addr_o), 64'h5008);
         chk("stall in_ready", 64'(in_ready_o), 64'd0);
         @(negedge clk);
      end
      chk("stall req pre-gnt", 64'(dbus_req_o), 64'd1);
      dbus_gnt_i = 1'b1;
      @(negedge clk);
      dbus_gnt_i = 1'b0;
      chk("stall req dropped", 64'(dbus_req_o), 64'd0);
      for (int i = 0; i < 2; i++) begin
         chk("stall resp in_ready", 64'(in_ready_o), 64'd0);
         chk("stall resp valid", 64'(out_valid_o), 64'd0);
         @(negedge clk);
      end
      dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'h1122_3344;
      @(negedge clk);
      dbus_rvalid_i = 1'b0; dbus_rdata_i = 32'h0;
      for (int i = 0; i < 2; i++) begin
         chk("stall out valid", 64'(out_valid_o), 64'd1);
         chk("stall out data", 64'(rsd_data_o), 64'h1122_3344);
         chk("stall out pc", 64'(pc_o), 64'hB00);
         chk("stall out in_ready", 64'(in_ready_o), 64'd0);
         @(negedge clk);
      end
      in_valid_i = 1'b0;
      out_ready_i = 1'b1;
      @(negedge clk);
      out_ready_i = 1'b0;
      chk("stall drained", 64'(out_valid_o), 64'd0);

      // reset while waiting for the response; late rvalid must be ignored
      drive_op(32'hC00, 1, 0, 3'b010, 32'h0000_C000, 32'h0);
      @(negedge clk);
      in_valid_i = 1'b0;
      dbus_gnt_i = 1'b1;
      @(negedge clk);
      dbus_gnt_i = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst2 req", 64'(dbus_req_o), 64'd0);
      chk("rst2 out_valid", 64'(out_valid_o), 64'd0);
      chk("rst2 in_ready", 64'(in_ready_o), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'h5555_AAAA;
      @(negedge clk);
      dbus_rvalid_i = 1'b0;
      chk("rst2 late rvalid", 64'(out_valid_o), 64'd0);
      chk("rst2 data", 64'(rsd_data_o), 64'd0);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/core_mem_lsu.md
Name: core_mem_lsu

Overview:
- Parametrised successor of the MEM-stage register slice; sits between EX and WB in the five-stage core.
- Passes non-memory instructions through with a valid/ready handshake.
- Executes loads and stores on a request/grant/response data bus, including byte, half, word and (XLEN=64) double access, sign/zero extension, byte-lane steering, and misaligned/access-fault detection.

Parameters:
XLEN, 32, data/address width; 32 or 64 only
RFIDX_WIDTH, 5, register index width
PC_SIZE, 32, PC width
INSTR_SIZE, 32, instruction width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid_i  input  1  EX stage presents an instruction
in_ready_o  output  1  stage accepts the instruction this cycle
pc_i  input  PC_SIZE  instruction PC
instr_i  input  INSTR_SIZE  instruction word
rsd_idx_i  input  RFIDX_WIDTH  destination register index
rsd_we_i  input  1  instruction writes rd
rsd_data_i  input  XLEN  ALU result; effective address for memory ops
rs2_data_i  input  XLEN  store data
is_load_i  input  1  load instruction
is_store_i  input  1  store instruction
funct3_i  input  3  [1:0] size (0=B, 1=H, 2=W, 3=D); [2] unsigned load
out_valid_o  output  1  WB-side payload valid
out_ready_i  input  1  WB accepts
pc_o  output  PC_SIZE  registered PC
instr_o  output  INSTR_SIZE  registered instruction
rsd_idx_o  output  RFIDX_WIDTH  registered rd index
rsd_we_o  output  1  rd write enable; forced 0 on exception
rsd_data_o  output  XLEN  load result, or ALU result for non-load ops
exc_o  output  2  0 none, 1 misaligned, 2 access fault, 3 illegal size
dbus_req_o  output  1  bus request
dbus_gnt_i  input  1  bus grant
dbus_we_o  output  1  write access
dbus_addr_o  output  XLEN  address aligned down to XLEN/8 bytes
dbus_be_o  output  XLEN/8  byte enables
dbus_wdata_o  output  XLEN  lane-steered store data
dbus_rvalid_i  input  1  response valid
dbus_rdata_i  input  XLEN  read data, full aligned word
dbus_err_i  input  1  response error; qualified by rvalid

Behaviour:
- Reset (async, rst_n low):
  - State IDLE.
  - All outputs 0, except in_ready_o=1.
  - A transaction in flight is abandoned; the bus slave tolerates a dropped request.
- Acceptance: in_ready_o = (state==IDLE) | (state==OUT & out_ready_i). Accept = in_valid_i & in_ready_o; all inputs are captured on accept.
- FSM states: IDLE, REQ, RESP, OUT.
- IDLE / accept decision:
  - Non-memory op -> OUT; out_valid_o=1 the next cycle (latency 1). Full throughput with back-to-back accept from OUT.
  - Memory op with size=3 and XLEN=32 -> OUT, exc=3.
  - Memory op with addr mod (1<<size) != 0 -> OUT, exc=1. No bus access.
  - Otherwise -> REQ.
- REQ:
  - dbus_req_o=1; addr, be, we, wdata are stable until grant.
  - dbus_gnt_i -> RESP; req drops the cycle after grant.
- RESP:
  - Waits for dbus_rvalid_i; stores also wait, as a write acknowledge.
  - On rvalid: capture data; if dbus_err_i, exc=2; -> OUT.
  - rvalid seen outside RESP is ignored.
- OUT:
  - out_valid_o=1; payload is held stable until out_ready_i.
  - out_ready_i without a new accept -> IDLE; with a new accept, follow the IDLE decision.
- Lane offset: off = addr[log2(XLEN/8)-1:0].
- Byte enables: dbus_be_o = ((1<<(1<<size))-1) << off.
- Store data: dbus_wdata_o = rs2_data_i << (8*off). Bytes outside the enables are don't-care.
- Load data:
  - Shift dbus_rdata_i right by 8*off and keep 8<<size bits.
  - Sign-extend to XLEN when funct3[2]=0, zero-extend when 1.
  - Size 3 ignores funct3[2].
- rsd_data_o: load result for loads; rsd_data_i otherwise (stores pass the address through).
- rsd_we_o = rsd_we_i & (exc==0) & !is_store.
- One transaction outstanding at most.

Test Plan:
- Non-memory, back-to-back: 3 consecutive ops with out_ready_i=1 -> out_valid_o every cycle, latency 1, payloads in order.
- LB: addr 0x1003, rdata 0x80FF_FF7F -> be=4'b1000, rsd_data_o=0xFFFF_FF80.
- LBU on the same address and data -> rsd_data_o=0x0000_0080.
- SH: addr 0x2002, rs2=0x1234_ABCD -> dbus_addr_o=0x2000, be=4'b1100, wdata[31:16]=0xABCD, rsd_we_o=0.
- Misaligned LW: addr 0x3002 -> no dbus_req_o, exc_o=1, rsd_we_o=0, out_valid_o after 1 cycle.
- Stalls: gnt delayed 3 cycles, rvalid 2 cycles later, out_ready_i low 2 cycles:
  - req held with a constant address;
  - in_ready_o=0 throughout;
  - payload held until the handshake.
- Access fault: rvalid with err=1 -> exc_o=2, rsd_we_o=0.
- Reset: rst_n low during RESP -> dbus_req_o=0 and out_valid_o=0 immediately; a later rvalid is ignored.
